// File: rtl/dpram_pack_writer.sv
// Packs a byte stream into INOUT_WIDTH-bit words and writes them to DPRAM port B,
// advancing a byte address that wraps at ADDR_LINE.
module dpram_pack_writer #(
    parameter int ADDR_WIDTH  = 9,
    parameter int ADDR_LINE   = 432,
    parameter int DATA_WIDTH  = 8,
    parameter int INOUT_WIDTH = 128
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [ADDR_WIDTH-1:0]  base_addr,
    input  logic [4:0]             size,
    input  logic [ADDR_WIDTH-1:0]  num_words,
    input  logic                   s_valid,
    input  logic [DATA_WIDTH-1:0]  s_data,
    output logic                   s_ready,
    output logic                   we_b,
    output logic [ADDR_WIDTH-1:0]  addr_b,
    output logic [INOUT_WIDTH-1:0] din_b,
    output logic [4:0]             size_b,
    output logic                   busy,
    output logic                   done,
    output logic                   err,
    output logic [1:0]             dbg_state
);

    localparam int                  LANES     = INOUT_WIDTH / DATA_WIDTH;
    localparam logic [ADDR_WIDTH:0] LINE      = (ADDR_WIDTH + 1)'(ADDR_LINE);
    localparam logic [4:0]          FULL_SIZE = 5'(LANES);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_PACK  = 2'd1,
        S_WRITE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t state_q, state_d;

    logic [INOUT_WIDTH-1:0] pack_q, pack_d;
    logic [4:0]             k_q, k_d;
    logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
    logic [4:0]             size_q, size_d;
    logic [ADDR_WIDTH-1:0]  cnt_q, cnt_d;
    logic                   err_q, err_d;
    logic                   we_b_q, we_b_d;
    logic [ADDR_WIDTH-1:0]  addr_b_q, addr_b_d;
    logic [INOUT_WIDTH-1:0] din_b_q, din_b_d;
    logic [4:0]             size_b_q, size_b_d;

    logic                   handshake;
    logic                   last_byte;
    logic                   fits;
    logic [ADDR_WIDTH:0]    addr_sum;
    logic [ADDR_WIDTH-1:0]  addr_next;
    logic [4:0]             size_clamped;
    logic [INOUT_WIDTH-1:0] word_out;

    // Stream handshake: a byte transfers on a rising edge where s_valid && s_ready;
    // s_valid may be held or dropped freely, s_ready depends only on the state register.
    assign handshake    = s_valid && s_ready;
    assign last_byte    = handshake && (k_q == size_q - 5'd1);
    assign addr_sum     = {1'b0, addr_q} + {{(ADDR_WIDTH - 4){1'b0}}, size_q};
    assign fits         = (addr_sum <= LINE);
    assign addr_next    = (addr_sum < LINE) ? addr_sum[ADDR_WIDTH-1:0]
                                            : ADDR_WIDTH'(addr_sum - LINE);
    assign size_clamped = (size == 5'd0 || size > FULL_SIZE) ? FULL_SIZE : size;

    // Completed word: the byte arriving now lands in lane k, unused upper lanes read as zero.
    always_comb begin
        word_out = '0;
        for (int i = 0; i < LANES; i++) begin
            if (5'(i) == k_q) begin
                word_out[i*DATA_WIDTH +: DATA_WIDTH] = s_data;
            end else if (5'(i) < size_q) begin
                word_out[i*DATA_WIDTH +: DATA_WIDTH] = pack_q[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = (num_words == '0) ? S_DONE : S_PACK;
                end
            end
            S_PACK: begin
                if (last_byte) begin
                    state_d = S_WRITE;
                end
            end
            S_WRITE: begin
                state_d = (cnt_q == ADDR_WIDTH'(1)) ? S_DONE : S_PACK;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_comb begin
        s_ready = 1'b0;
        busy    = 1'b0;
        done    = 1'b0;
        unique case (state_q)
            S_PACK: begin
                s_ready = 1'b1;
                busy    = 1'b1;
            end
            S_WRITE: begin
                busy = 1'b1;
            end
            S_DONE: begin
                busy = 1'b1;
                done = 1'b1;
            end
            default: begin
            end
        endcase
    end

    always_comb begin
        pack_d   = pack_q;
        k_d      = k_q;
        addr_d   = addr_q;
        size_d   = size_q;
        cnt_d    = cnt_q;
        err_d    = err_q;
        we_b_d   = 1'b0;
        addr_b_d = addr_b_q;
        din_b_d  = din_b_q;
        size_b_d = size_b_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    addr_d = base_addr;
                    size_d = size_clamped;
                    cnt_d  = num_words;
                    err_d  = 1'b0;
                    k_d    = 5'd0;
                end
            end
            S_PACK: begin
                if (handshake) begin
                    for (int i = 0; i < LANES; i++) begin
                        if (5'(i) == k_q) begin
                            pack_d[i*DATA_WIDTH +: DATA_WIDTH] = s_data;
                        end
                    end
                    k_d = k_q + 5'd1;
                end
                // Port-B outputs are registered here so they appear during the WRITE cycle;
                // a word that would cross ADDR_LINE leaves them untouched.
                if (last_byte && fits) begin
                    we_b_d   = 1'b1;
                    addr_b_d = addr_q;
                    size_b_d = size_q;
                    din_b_d  = word_out;
                end
            end
            S_WRITE: begin
                if (!fits) begin
                    err_d = 1'b1;
                end
                addr_d = addr_next;
                k_d    = 5'd0;
                cnt_d  = cnt_q - ADDR_WIDTH'(1);
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pack_q   <= '0;
            k_q      <= '0;
            addr_q   <= '0;
            size_q   <= '0;
            cnt_q    <= '0;
            err_q    <= 1'b0;
            we_b_q   <= 1'b0;
            addr_b_q <= '0;
            din_b_q  <= '0;
            size_b_q <= '0;
        end else begin
            pack_q   <= pack_d;
            k_q      <= k_d;
            addr_q   <= addr_d;
            size_q   <= size_d;
            cnt_q    <= cnt_d;
            err_q    <= err_d;
            we_b_q   <= we_b_d;
            addr_b_q <= addr_b_d;
            din_b_q  <= din_b_d;
            size_b_q <= size_b_d;
        end
    end

    assign we_b      = we_b_q;
    assign addr_b    = addr_b_q;
    assign din_b     = din_b_q;
    assign size_b    = size_b_q;
    assign err       = err_q;
    assign dbg_state = state_q;

    a_write_blocks_stream: assert property (@(posedge clk) disable iff (!rst_n) we_b |-> !s_ready);
    a_done_while_busy:     assert property (@(posedge clk) disable iff (!rst_n) done |-> busy);
    a_no_write_on_done:    assert property (@(posedge clk) disable iff (!rst_n) !(we_b && done));

endmodule

// File: tb/tb_dpram_pack_writer.sv
// Randomized bench for dpram_pack_writer: a transfer-level model predicts every
// port-B write and the resulting DPRAM contents.
module tb_dpram_pack_writer;

  localparam int AW = 9;
  localparam int LINE = 432;
  localparam int IW = 128;
  localparam int EW = AW + 5 + IW;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic [AW-1:0] base_addr;
  logic [4:0]    size;
  logic [AW-1:0] num_words;
  logic          s_valid;
  logic [7:0]    s_data;
  logic          s_ready;
  logic          we_b;
  logic [AW-1:0] addr_b;
  logic [IW-1:0] din_b;
  logic [4:0]    size_b;
  logic          busy;
  logic          done;
  logic          err;
  logic [1:0]    dbg_state;

  int n_chk = 0;
  int n_err = 0;
  int wr_count = 0;

  logic [EW-1:0] exp_q[$];
  logic [7:0]    mem_obs [0:LINE-1];
  logic [7:0]    mem_exp [0:LINE-1];

  dpram_pack_writer #(
    .ADDR_WIDTH(AW), .ADDR_LINE(LINE), .DATA_WIDTH(8), .INOUT_WIDTH(IW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr), .size(size),
    .num_words(num_words), .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
    .we_b(we_b), .addr_b(addr_b), .din_b(din_b), .size_b(size_b), .busy(busy),
    .done(done), .err(err), .dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // scoreboard: every observed write must match the head of exp_q
  always @(negedge clk) begin
    logic [EW-1:0] e;
    if (rst_n && we_b) begin
      wr_count++;
      for (int i = 0; i < 16; i++) begin
        if (i < int'(size_b) && int'(addr_b) + i < LINE)
          mem_obs[int'(addr_b) + i] = din_b[8*i +: 8];
      end
      if (exp_q.size() == 0) begin
        check("unexpected_write", 1, 0);
      end else begin
        e = exp_q.pop_front();
        check("addr_b", addr_b, e[EW-1 -: AW]);
        check("size_b", size_b, e[IW +: 5]);
        check("din_b", din_b, e[IW-1:0]);
      end
    end
  end

  function automatic bit pick_valid(input int vmode, input int cyc);
    if (vmode == 0) return 1'b1;
    if (vmode == 1) return cyc[0];
    return ($urandom_range(0, 3) != 0);
  endfunction

  function automatic int mem_diffs();
    int d = 0;
    for (int i = 0; i < LINE; i++) if (mem_obs[i] !== mem_exp[i]) d++;
    return d;
  endfunction

  // pat: 0 = incrementing, 1 = all 0xFF, 2 = random; vmode: 0 = continuous, 1 = toggling, 2 = random
  task automatic run_xfer(input int base, input int sz, input int nw, input int pat,
                          input int vmode, input bit inject);
    int s, total, idx, cyc, addr, pend;
    bit exp_err;
    logic [7:0] bytes[$];
    bit fit[$];
    logic [IW-1:0] din;

    s = (sz == 0 || sz > 16) ? 16 : sz;
    total = nw * s;
    for (int i = 0; i < total; i++)
      bytes.push_back(pat == 0 ? 8'(i) : pat == 1 ? 8'hFF : 8'($urandom_range(0, 255)));

    addr = base;
    exp_err = 1'b0;
    for (int w = 0; w < nw; w++) begin
      din = '0;
      for (int i = 0; i < s; i++) din[8*i +: 8] = bytes[w*s + i];
      if (addr + s <= LINE) begin
        exp_q.push_back({AW'(addr), 5'(s), din});
        fit.push_back(1'b1);
        for (int i = 0; i < s; i++) mem_exp[addr + i] = bytes[w*s + i];
      end else begin
        exp_err = 1'b1;
        fit.push_back(1'b0);
      end
      addr = (addr + s) % LINE;
    end

    @(posedge clk); #1;
    start = 1'b1; base_addr = AW'(base); size = 5'(sz); num_words = AW'(nw);
    @(posedge clk); #1;
    start = 1'b0;
    idx = 0; cyc = 0; pend = -1;
    s_valid = (total > 0) && pick_valid(vmode, cyc);
    s_data = (total > 0) ? bytes[0] : 8'h00;
    @(negedge clk);
    check("busy_after_start", busy, 1);
    check("err_clear_on_start", err, 0);
    check("s_ready_after_start", s_ready, (nw != 0));

    while ((idx < total || pend >= 0) && cyc < 2000) begin
      if (pend >= 0) begin
        check("we_b_after_last_byte", we_b, fit[pend]);
        check("s_ready_low_in_write", s_ready, 0);
        pend = -1;
      end else if (s_valid && s_ready) begin
        idx++;
        if (idx % s == 0) pend = idx / s - 1;
      end
      @(posedge clk); #1;
      cyc++;
      start = inject && (cyc == 2);
      if (inject && cyc == 2) begin
        base_addr = AW'(3); size = 5'd1; num_words = '0;
      end
      s_valid = (idx < total) && pick_valid(vmode, cyc);
      s_data = (idx < total) ? bytes[idx] : 8'h00;
      @(negedge clk);
    end
    if (cyc >= 2000) check("transfer_timeout", 0, 1);

    check("done_pulse", done, 1);
    check("busy_in_done", busy, 1);
    check("err_at_done", err, exp_err);
    @(negedge clk);
    check("done_one_cycle", done, 0);
    check("busy_after_done", busy, 0);
    check("writes_outstanding", exp_q.size(), 0);
    check("dpram_contents", mem_diffs(), 0);
  endtask

  task automatic reset_mid();
    int fed, cyc, wrs;
    @(posedge clk); #1;
    start = 1'b1; base_addr = AW'(200); size = 5'd16; num_words = AW'(1);
    @(posedge clk); #1;
    start = 1'b0; s_valid = 1'b1; s_data = 8'hA5;
    fed = 0; cyc = 0;
    while (fed < 5 && cyc < 100) begin
      @(negedge clk);
      if (s_valid && s_ready) fed++;
      @(posedge clk); #1;
      cyc++;
      s_data = 8'(8'hA5 + fed);
      if (fed == 5) s_valid = 1'b0;
    end
    check("busy_before_reset", busy, 1);
    wrs = wr_count;
    #2 rst_n = 1'b0;
    #1;
    check("rst_s_ready", s_ready, 0);
    check("rst_we_b", we_b, 0);
    check("rst_addr_b", addr_b, 0);
    check("rst_din_b", din_b, 0);
    check("rst_size_b", size_b, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    s_valid = 1'b1;
    repeat (20) @(negedge clk);
    s_valid = 1'b0;
    check("no_write_after_reset", wr_count, wrs);
    check("idle_after_reset", busy, 0);
    // DPRAM contents survive the block reset
    check("dpram_after_reset", mem_diffs(), 0);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; base_addr = '0; size = '0; num_words = '0;
    s_valid = 1'b0; s_data = '0;
    for (int i = 0; i < LINE; i++) begin
      mem_obs[i] = 8'h00;
      mem_exp[i] = 8'h00;
    end
    #12;
    check("reset_state", dbg_state, 0);
    check("reset_busy", busy, 0);
    check("reset_we_b", we_b, 0);
    check("reset_s_ready", s_ready, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    run_xfer(16, 16, 1, 0, 0, 1'b0);   // single full word
    run_xfer(48, 8, 2, 1, 0, 1'b0);    // partial words, upper lanes zero
    run_xfer(424, 8, 2, 2, 0, 1'b0);   // ends exactly at 431, then wraps to 0
    run_xfer(428, 8, 1, 2, 0, 1'b0);   // straddles ADDR_LINE: dropped, err set
    run_xfer(100, 16, 2, 2, 1, 1'b1);  // toggling valid, start ignored while busy
    reset_mid();
    run_xfer(200, 0, 1, 2, 0, 1'b0);   // size 0 acts as 16
    run_xfer(50, 5, 0, 2, 0, 1'b0);    // num_words 0
    run_xfer(300, 1, 3, 2, 2, 1'b0);   // single-byte words
    run_xfer(10, 31, 1, 2, 2, 1'b0);   // oversize clamps to 16

    for (int t = 0; t < 10; t++)
      run_xfer($urandom_range(0, LINE - 1), $urandom_range(0, 31), $urandom_range(0, 4),
               2, $urandom_range(0, 2), 1'($urandom_range(0, 1)));

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/dpram_pack_writer.md
# dpram_pack_writer

Write-side initiator for the byte-addressed DPRAM in the systolic-array datapath. It accepts a byte stream with a valid/ready handshake and packs `size` bytes into one INOUT_WIDTH-bit word. It then issues a single-cycle port-B write (`we_b`/`addr_b`/`din_b`/`size_b`) and advances the byte address by `size`, wrapping at ADDR_LINE. It loads activation and weight tiles into the DPRAM ahead of port-A reads.

## Interface
- ADDR_WIDTH, 9, byte-address width of DPRAM.
- ADDR_LINE, 432, number of byte locations; valid addresses 0..ADDR_LINE-1.
- DATA_WIDTH, 8, width of one byte lane and of `s_data`.
- INOUT_WIDTH, 128, port-B data width; lanes = INOUT_WIDTH/DATA_WIDTH = 16.
- clk  in  1  clock; all state on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- start  in  1  one-cycle request to begin a transfer; sampled in IDLE only.
- base_addr  in  ADDR_WIDTH  first byte address; must be < ADDR_LINE.
- size  in  5  bytes per word, 1..16; 0 or >16 is treated as 16.
- num_words  in  ADDR_WIDTH  words to write; 0 completes immediately.
- s_valid  in  1  input byte valid.
- s_data  in  DATA_WIDTH  input byte.
- s_ready  out  1  block accepts byte this cycle.
- we_b  out  1  DPRAM port-B write enable.
- addr_b  out  ADDR_WIDTH  DPRAM port-B byte address.
- din_b  out  INOUT_WIDTH  DPRAM port-B data.
- size_b  out  5  DPRAM port-B byte count.
- busy  out  1  high from accepted start until done.
- done  out  1  one-cycle pulse when the transfer ends.
- err  out  1  sticky: a word was dropped for crossing ADDR_LINE; cleared on next accepted start.

## Operation
- States: IDLE, PACK, WRITE, DONE.
- IDLE:
  - start=1 latches base_addr into addr_q, clamped size into size_q, num_words into cnt_q, and clears err.
  - Goes to DONE if num_words=0, else PACK.
  - start in any other state is ignored.
- PACK:
  - s_ready=1.
  - Each handshake (s_valid&&s_ready) writes s_data into lane k of the pack register, bits [8k+7:8k], then increments k.
  - Lane 0 maps to the lowest address: DPRAM stores mem[addr_b+i] = din_b lane i.
  - When the handshake with k=size_q-1 occurs, go to WRITE.
- WRITE (exactly one cycle, s_ready=0):
  - Drive addr_b=addr_q, size_b=size_q, din_b=pack register with lanes >= size_q forced to 0.
  - If addr_q+size_q <= ADDR_LINE: we_b=1.
  - Otherwise: we_b=0 and err is set. The word is dropped, but the address still advances.
  - Next addr_q = addr_q+size_q if that is < ADDR_LINE, else addr_q+size_q-ADDR_LINE. Compute the sum at ADDR_WIDTH+1 bits.
  - Reset k to 0 and decrement cnt_q. Go to DONE if cnt_q was 1, else PACK.
- DONE: done=1 for one cycle, busy=0 next cycle, return to IDLE.
- busy=1 in PACK, WRITE and DONE; done and busy are never both 0 between start and return to IDLE.
- When we_b=0, din_b, addr_b and size_b hold their last values.

## Timing
- Reset (rst_n=0, asynchronous): state=IDLE and all outputs 0: s_ready, we_b, addr_b, din_b, size_b, busy, done, err. Pack register, k, addr_q, size_q and cnt_q are cleared.
- Reset mid-transfer discards any partial word; no write is issued.
- start at edge T: busy=1 and s_ready=1 from T+1.
- Last byte accepted at edge N: we_b=1 during cycle N+1 (registered output); s_ready=0 during cycle N+1; s_ready=1 again from N+2 if more words remain.
- Throughput: size_q+1 cycles per word with continuous s_valid.
- s_valid low in PACK stalls with no state change; bytes offered while s_ready=0 are not consumed.
- After the last word's WRITE cycle, DONE follows in the next cycle; busy falls on the cycle after DONE.
- num_words=0: start at T, done=1 during T+1, and no we_b pulse occurs.

## Test plan
- Single full word: base_addr=16, size=16, num_words=1, bytes 0x00..0x0F.
  - Required: one we_b pulse with addr_b=16, size_b=16, din_b=128'h0F0E0D0C0B0A09080706050403020100.
  - Required: done one cycle later; DPRAM mem[16..31] match.
- Partial word: base_addr=48, size=8, num_words=2, all bytes 0xFF.
  - Required: writes at addr_b=48 then 56.
  - Required: din_b upper 64 bits = 0 for both; mem[48..63]=0xFF afterwards.
- Wrap: ADDR_LINE=432, base_addr=424, size=8, num_words=2.
  - Required: first write at 424 (ends at 431).
  - Required: second write at addr_b=0; err=0.
- Straddle drop: base_addr=428, size=8, num_words=1.
  - Required: no we_b pulse, err=1 after the WRITE cycle, done asserted.
  - Required: err cleared by the next start.
- Backpressure/reset: s_valid toggled every other cycle shows no lost or duplicated bytes. rst_n pulsed low after 5 of 16 bytes returns all outputs to 0 with no write. start during busy is ignored.
- Edge sizes: size=0 behaves as 16. num_words=0 gives done with no we_b. size=1 with num_words=3 gives writes at base, base+1, base+2.
